fifo_drain_arbiter: RTL and testbench

- Round-robin arbiter that drains up to `N_SRC` FIFO read ports into one valid/ready output stream, in bursts of at most `BURST` words per grant.
- Sits on the read side of the FIFO bank, in the read-clock domain.
- Drives each FIFO's `rd_en` from its `rd_rdy`.
- Accounts for the FIFO's one-cycle registered `dout` latency.
- Tags every output word with its source index.

---
 rtl/fifo_drain_arbiter_if.sv | 36 +++
 rtl/fifo_drain_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_arbiter_if.sv
// Bundle of FIFO read-side ports and the tagged valid/ready output stream.
// The master modport is the arbiter's view; the slave modport is the FIFO bank / sink side.
interface fifo_drain_arbiter_if #(
    parameter int N_SRC = 4,
    parameter int DW    = 32
);
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]    src_rdy;
    logic [N_SRC-1:0]    src_rd_en;
    logic [N_SRC*DW-1:0] src_dout;
    logic [DW-1:0]       out_data;
    logic [SW-1:0]       out_src;
    logic                out_valid;
    logic                out_ready;

    modport master (
        input  src_rdy,
        input  src_dout,
        input  out_ready,
        output src_rd_en,
        output out_data,
        output out_src,
        output out_valid
    );

    modport slave (
        output src_rdy,
        output src_dout,
        output out_ready,
        input  src_rd_en,
        input  out_data,
        input  out_src,
        input  out_valid
    );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst drain of N_SRC FIFO read ports into one tagged valid/ready stream.
// Define FIFO_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins arbitration.
module fifo_drain_arbiter #(
    parameter int N_SRC = 4,
    parameter int DW    = 32,
    parameter int BURST = 4
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   enable,
    output logic                   busy,
    fifo_drain_arbiter_if.master   bus
);
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [1:0] {IDLE, POP, CAPTURE, HOLD} state_t;

    state_t        state, state_next;
    logic [SW-1:0] grant, grant_next;
    logic [SW-1:0] pick;
    logic          pick_valid;
    logic [CW-1:0] count, count_next;
    logic [DW-1:0] data_q, data_next;
    logic [SW-1:0] src_q, src_next;
    logic          valid_q, valid_next;
`ifndef FIFO_ARB_FIXED_PRIO_EN
    logic [SW-1:0] ptr, ptr_next;
`endif

    // Scan downward so the last hit is the closest ready source to the search origin.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (bus.src_rdy[SW'(i)]) begin
                pick       = SW'(i);
                pick_valid = 1'b1;
            end
        end
`else
        for (int k = N_SRC - 1; k >= 0; k--) begin
            int s;
            s = int'(ptr) + k;
            if (s >= N_SRC) s = s - N_SRC;
            if (bus.src_rdy[SW'(s)]) begin
                pick       = SW'(s);
                pick_valid = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        count_next = count;
        data_next  = data_q;
        src_next   = src_q;
        valid_next = valid_q;
`ifndef FIFO_ARB_FIXED_PRIO_EN
        ptr_next   = ptr;
`endif
        case (state)
            IDLE: begin
                if (enable && pick_valid) begin
                    grant_next = pick;
                    count_next = '0;
                    state_next = POP;
                end
            end
            POP: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                // FIFO dout is registered, so the word popped last cycle is visible now.
                data_next  = bus.src_dout[int'(grant)*DW +: DW];
                src_next   = grant;
                valid_next = 1'b1;
                count_next = count + CW'(1);
                state_next = HOLD;
            end
            HOLD: begin
                if (valid_q && bus.out_ready) begin
                    valid_next = 1'b0;
                    if ((count < CW'(BURST)) && bus.src_rdy[grant]) begin
                        state_next = POP;
                    end else begin
`ifndef FIFO_ARB_FIXED_PRIO_EN
                        ptr_next   = (grant == SW'(N_SRC - 1)) ? '0 : grant + SW'(1);
`endif
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            grant   <= '0;
            count   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            ptr     <= '0;
`endif
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            count   <= count_next;
            data_q  <= data_next;
            src_q   <= src_next;
            valid_q <= valid_next;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            ptr     <= ptr_next;
`endif
        end
    end

    always_comb begin
        bus.src_rd_en = '0;
        if (state == POP) bus.src_rd_en[grant] = 1'b1;
    end

    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.out_valid = valid_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Scoreboard bench for fifo_drain_arbiter: a FIFO bank model feeds the DUT, expected words
// are queued by the stimulus, and a monitor compares every accepted output word.
`timescale 1ns/1ps
module tb_fifo_drain_arbiter;
    localparam int N_SRC = 4;
    localparam int DW    = 32;
    localparam int BURST = 4;
    localparam int DEPTH = 64;

    logic CLK = 1'b0;
    logic reset_n;
    logic enable;
    logic busy;

    always #5 CLK = ~CLK;

    fifo_drain_arbiter_if #(.N_SRC(N_SRC), .DW(DW)) bus ();

    fifo_drain_arbiter #(.N_SRC(N_SRC), .DW(DW), .BURST(BURST)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .enable  (enable),
        .busy    (busy),
        .bus     (bus)
    );

    // FIFO bank model: rd_rdy is non-empty, dout updates one edge after rd_en.
    logic [DW-1:0]    mem [N_SRC][DEPTH];
    int               wr_ptr [N_SRC];
    int               rd_ptr [N_SRC];
    logic [DW-1:0]    dout [N_SRC];
    logic [N_SRC-1:0] rdy_m;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) rdy_m[i] = (wr_ptr[i] != rd_ptr[i]);
    end

    always @(posedge CLK) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.src_rd_en[i] && (rd_ptr[i] != wr_ptr[i])) begin
                dout[i]   <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    assign bus.src_rdy = rdy_m;
    for (genvar g = 0; g < N_SRC; g++) begin : g_dout
        assign bus.src_dout[g*DW +: DW] = dout[g];
    end

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] data;
    } word_t;

    word_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    accepted = 0;
    int    pulses [N_SRC];

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [DW-1:0] data);
        mem[src][wr_ptr[src]] = data;
        wr_ptr[src] = wr_ptr[src] + 1;
    endtask

    task automatic expectWord(input int src, input logic [DW-1:0] data);
        word_t w;
        w.src  = 2'(src);
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        repeat (2) @(negedge CLK);
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checkOutput({name, "_timeout"}, DW'(n >= budget), '0);
    endtask

    task automatic waitValid(input int budget, input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checkOutput({name, "_valid_timeout"}, DW'(n >= budget), '0);
    endtask

    // Monitor samples just before each rising edge, when the handshake is about to resolve.
    initial begin
        word_t w;
        forever begin
            @(negedge CLK);
            #4;
            for (int i = 0; i < N_SRC; i++) if (bus.src_rd_en[i]) pulses[i]++;
            checkOutput("rd_en_while_valid", DW'((bus.src_rd_en != '0) && bus.out_valid), '0);
            if (reset_n && bus.out_valid && bus.out_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word got src=%0d data=%h expected none", bus.out_src, bus.out_data);
                end else begin
                    w = exp_q.pop_front();
                    checkOutput("out_src", DW'(bus.out_src), DW'(w.src));
                    checkOutput("out_data", bus.out_data, w.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p0, p1, p2, p3, base, n;
        reset_n       = 1'b0;
        enable        = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_out_valid", DW'(bus.out_valid), '0);
        checkOutput("rst_out_data", bus.out_data, '0);
        checkOutput("rst_out_src", DW'(bus.out_src), '0);
        checkOutput("rst_rd_en", DW'(bus.src_rd_en), '0);
        checkOutput("rst_busy", DW'(busy), '0);
        reset_n       = 1'b1;
        enable        = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge CLK);

        $display("[TB] single source short burst");
        p0 = pulses[0]; p1 = pulses[1]; p2 = pulses[2]; p3 = pulses[3];
        applyStimulus(2, 32'hA0);
        applyStimulus(2, 32'hA1);
        expectWord(2, 32'hA0);
        expectWord(2, 32'hA1);
        waitIdle(60, "single");
        checkOutput("single_pulses_src2", DW'(pulses[2] - p2), 32'd2);
        checkOutput("single_pulses_other", DW'((pulses[0] - p0) + (pulses[1] - p1) + (pulses[3] - p3)), '0);
        checkOutput("single_busy_end", DW'(busy), '0);

        $display("[TB] four full sources, bursts of four");
        reset_n = 1'b0;
        @(negedge CLK);
        reset_n = 1'b1;
        for (int s = 0; s < N_SRC; s++)
            for (int k = 0; k < 8; k++) applyStimulus(s, DW'(s * 256 + k));
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int s = 0; s < N_SRC; s++)
            for (int k = 0; k < 8; k++) expectWord(s, DW'(s * 256 + k));
`else
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N_SRC; s++)
                for (int k = r * 4; k < r * 4 + 4; k++) expectWord(s, DW'(s * 256 + k));
`endif
        waitIdle(300, "rr");

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(1, 32'hB0);
        applyStimulus(1, 32'hB1);
        applyStimulus(1, 32'hB2);
        expectWord(1, 32'hB0);
        expectWord(1, 32'hB1);
        expectWord(1, 32'hB2);
        waitValid(20, "bp");
        repeat (10) begin
            @(negedge CLK);
            checkOutput("bp_data_stable", bus.out_data, 32'hB0);
            checkOutput("bp_src_stable", DW'(bus.out_src), 32'd1);
            checkOutput("bp_rd_en_low", DW'(bus.src_rd_en), '0);
        end
        bus.out_ready = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("bp_pop_after_release", DW'(bus.src_rd_en), 32'b0010);
        waitIdle(60, "bp");

        $display("[TB] enable gating mid burst");
        base = accepted;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2, DW'(32'hC0 + k));
            expectWord(2, DW'(32'hC0 + k));
        end
        n = 0;
        while (accepted < base + 2 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("en_two_words_timeout", DW'(n >= 40), '0);
        enable = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("en_burst_words", DW'(accepted - base), 32'd4);
        repeat (8) @(negedge CLK);
        checkOutput("en_gated_busy", DW'(busy), '0);
        checkOutput("en_gated_rd_en", DW'(bus.src_rd_en), '0);
        enable = 1'b1;
        waitIdle(60, "en");
        checkOutput("en_total_words", DW'(accepted - base), 32'd6);

        $display("[TB] reset while holding a word");
        bus.out_ready = 1'b0;
        applyStimulus(1, 32'hF0);
        applyStimulus(1, 32'hF1);
        expectWord(1, 32'hF0);
        expectWord(1, 32'hF1);
        waitValid(20, "rst");
        @(negedge CLK);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_hold_valid", DW'(bus.out_valid), '0);
        checkOutput("rst_hold_data", bus.out_data, '0);
        checkOutput("rst_hold_src", DW'(bus.out_src), '0);
        checkOutput("rst_hold_rd_en", DW'(bus.src_rd_en), '0);
        checkOutput("rst_hold_busy", DW'(busy), '0);
        void'(exp_q.pop_front());
        @(negedge CLK);
        reset_n = 1'b1;
        applyStimulus(3, 32'hE0);
        expectWord(3, 32'hE0);
        bus.out_ready = 1'b1;
        waitIdle(60, "rst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
